// File: rtl/bound_flasher_pkg.sv
// Shared definitions for the bound flasher family.
// Holds the stage encoding (unchanged from the 16-lamp block) and the
// level-width helper used to size the lit-lamp counter.
package bound_flasher_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP1  = 3'd1,
        DN1  = 3'd2,
        UP2  = 3'd3,
        DN2  = 3'd4,
        UP3  = 3'd5,
        DN3  = 3'd6,
        BAD  = 3'd7
    } stage_e;

    localparam int unsigned STAGE_W = 3;

    // Bits needed to hold a lit-lamp count of 0..n_lamps.
    function automatic int unsigned lvl_w(input int unsigned n_lamps);
        return $clog2(n_lamps + 1);
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler shared by the display blocks.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset, clears the divider count
//   step_div - tick every step_div+1 cycles (0 = every cycle)
//   tick_c   - combinational step strobe, high on the compare cycle
module step_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] step_div,
    output logic             tick_c
);

    logic [DIV_W-1:0] div_cnt;

    // Compare against the live step_div so a new rate applies at the next compare.
    assign tick_c = (div_cnt >= step_div);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/bound_flasher_gen.sv
// Parametrised bound flasher: drives an N-lamp thermometer bar through
// three fill/drain phases with two bound points, flick kickback,
// programmable step rate and optional auto-repeat.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   flick     - start / kickback request, sampled on step ticks
//   auto_rpt  - restart at UP1 instead of idling when DN3 completes
//   step_div  - step every step_div+1 clocks
//   lamps     - thermometer bar, lamps[level-1:0] lit
//   stage     - current stage encoding
//   level     - count of lit lamps
//   busy      - high whenever stage is not IDLE
//   done      - one-cycle pulse when the sequence completes
module bound_flasher_gen
    import bound_flasher_pkg::*;
#(
    parameter int unsigned N_LAMPS = 16,
    parameter int unsigned BOUND_A = 5,
    parameter int unsigned BOUND_B = 10,
    parameter int unsigned DIV_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flick,
    input  logic                      auto_rpt,
    input  logic [DIV_W-1:0]          step_div,
    output logic [N_LAMPS-1:0]        lamps,
    output logic [STAGE_W-1:0]        stage,
    output logic [lvl_w(N_LAMPS)-1:0] level,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned LVL_W = lvl_w(N_LAMPS);
    // Kickback levels: the new level at which lamp BOUND_A / BOUND_B lights.
    localparam logic [LVL_W-1:0] KA   = LVL_W'(BOUND_A + 1);
    localparam logic [LVL_W-1:0] KB   = LVL_W'(BOUND_B + 1);
    localparam logic [LVL_W-1:0] LO_B = LVL_W'(BOUND_A);
    localparam logic [LVL_W-1:0] FULL = LVL_W'(N_LAMPS);

    stage_e           st;
    logic             tick_c;
    logic             up_c;
    logic             kick_c;
    logic [LVL_W-1:0] l_nxt_c;

    step_prescaler #(
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .step_div (step_div),
        .tick_c   (tick_c)
    );

    assign stage = st;

    // Thermometer decode of a lit-lamp count.
    function automatic logic [N_LAMPS-1:0] therm(input logic [LVL_W-1:0] n);
        logic [N_LAMPS-1:0] t;
        t = '0;
        for (int i = 0; i < int'(N_LAMPS); i++) begin
            t[i] = (i < int'(n));
        end
        return t;
    endfunction

    // Step direction and candidate level; IDLE counts as up so acceptance lands on 1.
    always_comb begin
        up_c    = (st == IDLE) || (st == UP1) || (st == UP2) || (st == UP3);
        l_nxt_c = up_c ? (level + LVL_W'(1)) : (level - LVL_W'(1));
        kick_c  = flick && ((l_nxt_c == KA) || (l_nxt_c == KB));
    end

    // Stage sequencer with registered level, lamps, busy and done.
    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= IDLE;
            level <= '0;
            lamps <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (st == BAD) begin
                st    <= IDLE;
                level <= '0;
                lamps <= '0;
                busy  <= 1'b0;
            end else if (tick_c) begin
                if ((st != IDLE) || flick) begin
                    level <= l_nxt_c;
                    lamps <= therm(l_nxt_c);
                end
                case (st)
                    IDLE: if (flick) begin
                        st   <= UP1;
                        busy <= 1'b1;
                    end
                    UP1: if (l_nxt_c == KA) st <= DN1;
                    DN1: if (l_nxt_c == '0) st <= UP2;
                    UP2: begin
                        if (kick_c)             st <= DN1;
                        else if (l_nxt_c == KB) st <= DN2;
                    end
                    DN2: if (l_nxt_c == LO_B) st <= UP3;
                    UP3: begin
                        if (kick_c)               st <= DN2;
                        else if (l_nxt_c == FULL) st <= DN3;
                    end
                    DN3: if (l_nxt_c == '0) begin
                        // Auto-repeat parks in UP1 at level 0; the next tick lights lamp 0.
                        done <= 1'b1;
                        st   <= auto_rpt ? UP1 : IDLE;
                        busy <= auto_rpt;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Self-checking bench for bound_flasher_gen (N=16, A=5, B=10).
// A cycle model pushes expected outputs each clock; a monitor pops and
// compares them. Directed sequences check the documented lamp patterns.
module tb_bound_flasher_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        flick;
    logic        auto_rpt;
    logic [7:0]  step_div;
    logic [15:0] lamps;
    logic [2:0]  stage;
    logic [4:0]  level;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] lamps;
        logic [4:0]  lvl;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb_q[$];

    bound_flasher_gen #(
        .N_LAMPS (16),
        .BOUND_A (5),
        .BOUND_B (10),
        .DIV_W   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flick    (flick),
        .auto_rpt (auto_rpt),
        .step_div (step_div),
        .lamps    (lamps),
        .stage    (stage),
        .level    (level),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: behavioural restatement of the stage table.
    int m_st = 0, m_l = 0, m_div = 0;
    bit m_done, m_tick;
    always @(posedge clk) begin
        exp_t e;
        m_done = 1'b0;
        if (rst) begin
            m_st = 0; m_l = 0; m_div = 0;
        end else begin
            m_tick = (m_div >= int'(step_div));
            m_div  = m_tick ? 0 : m_div + 1;
            if (m_tick) begin
                case (m_st)
                    0: if (flick) begin m_st = 1; m_l = 1; end
                    1: begin m_l++; if (m_l == 6) m_st = 2; end
                    2: begin m_l--; if (m_l == 0) m_st = 3; end
                    3: begin
                        m_l++;
                        if (flick && (m_l == 6 || m_l == 11)) m_st = 2;
                        else if (m_l == 11) m_st = 4;
                    end
                    4: begin m_l--; if (m_l == 5) m_st = 5; end
                    5: begin
                        m_l++;
                        if (flick && (m_l == 6 || m_l == 11)) m_st = 4;
                        else if (m_l == 16) m_st = 6;
                    end
                    6: begin
                        m_l--;
                        if (m_l == 0) begin m_done = 1'b1; m_st = auto_rpt ? 1 : 0; end
                    end
                    default: begin m_st = 0; m_l = 0; end
                endcase
            end
        end
        e.st    = 3'(m_st);
        e.lamps = 16'((32'd1 << m_l) - 32'd1);
        e.lvl   = 5'(m_l);
        e.busy  = (m_st != 0);
        e.done  = m_done;
        sb_q.push_back(e);
    end

    // Monitor: compare DUT against the oldest expected entry, away from the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_stage", 32'(stage), 32'(e.st));
            check("sb_lamps", 32'(lamps), 32'(e.lamps));
            check("sb_level", 32'(level), 32'(e.lvl));
            check("sb_busy",  32'(busy),  32'(e.busy));
            check("sb_done",  32'(done),  32'(e.done));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int st, input int lv, input string tag);
        int n = 0;
        while (!(int'(stage) == st && int'(level) == lv) && n < 1000) begin
            cyc();
            n++;
        end
        check(tag, 32'(n < 1000), 32'd1);
    endtask

    // Hold flick until the DUT leaves IDLE.
    task automatic start_seq();
        int n = 0;
        @(negedge clk) flick = 1'b1;
        do begin cyc(); n++; end while (stage == 3'd0 && n < 100);
        flick = 1'b0;
        check("accept", 32'(stage != 3'd0), 32'd1);
    endtask

    logic [15:0] exp_tp [6] = '{16'h003F, 16'h0000, 16'h07FF, 16'h001F, 16'hFFFF, 16'h0000};

    initial begin
        int          lv_q[$];
        logic [15:0] lm_q[$];
        logic [15:0] tp[$];
        logic [15:0] prev;
        int          steps, ndone, last;

        rst = 1'b1; flick = 1'b0; auto_rpt = 1'b0; step_div = 8'd0;
        cyc(); cyc();
        check("rst_lamps", 32'(lamps), 32'h0);
        check("rst_stage", 32'(stage), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_done",  32'(done),  32'h0);
        @(negedge clk) rst = 1'b0;
        cyc();

        // Normal flow with a single-cycle flick.
        steps = 0; ndone = 0;
        @(negedge clk) flick = 1'b1;
        for (int c = 0; c < 200; c++) begin
            cyc();
            flick = 1'b0;
            steps++;
            lv_q.push_back(int'(level));
            lm_q.push_back(lamps);
            if (done) begin ndone++; break; end
        end
        check("nf_steps", 32'(steps), 32'd56);
        for (int i = 1; i < lv_q.size() - 1; i++)
            if ((lv_q[i] - lv_q[i-1]) != (lv_q[i+1] - lv_q[i])) tp.push_back(lm_q[i]);
        tp.push_back(lm_q[lm_q.size() - 1]);
        check("nf_tp_cnt", 32'(tp.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < tp.size()) check($sformatf("nf_tp%0d", i), 32'(tp[i]), 32'(exp_tp[i]));
        for (int c = 0; c < 60; c++) begin
            cyc();
            if (done) ndone++;
        end
        check("nf_done_cnt", 32'(ndone), 32'd1);
        check("nf_idle", 32'(stage), 32'd0);

        // UP2 kickback at lamp BOUND_A.
        start_seq();
        wait_for(3, 5, "w_up2");
        @(negedge clk) flick = 1'b1;
        cyc();
        flick = 1'b0;
        check("k2_stage", 32'(stage), 32'd2);
        check("k2_lamps", 32'(lamps), 32'h003F);
        cyc();
        check("k2_lamps1", 32'(lamps), 32'h001F);
        check("k2_stage1", 32'(stage), 32'd2);
        wait_for(3, 0, "w_k2_rep");
        check("k2_rep_lamps", 32'(lamps), 32'h0000);
        wait_for(0, 0, "w_k2_idle");

        // UP3 kickback at lamp BOUND_B.
        start_seq();
        wait_for(5, 10, "w_up3");
        @(negedge clk) flick = 1'b1;
        cyc();
        flick = 1'b0;
        check("k3_stage", 32'(stage), 32'd4);
        check("k3_lamps", 32'(lamps), 32'h07FF);
        wait_for(5, 5, "w_k3_drain");
        check("k3_drain", 32'(lamps), 32'h001F);
        wait_for(6, 16, "w_k3_full");
        check("k3_full", 32'(lamps), 32'hFFFF);
        wait_for(0, 0, "w_k3_idle");

        // Prescaler: every 4th clock, then live switch to every clock.
        step_div = 8'd3;
        start_seq();
        prev = lamps; last = -1;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (lamps != prev) begin
                if (last >= 0) check("div3_gap", 32'(c - last), 32'd4);
                last = c;
                prev = lamps;
            end
        end
        step_div = 8'd0;
        prev = lamps;
        for (int c = 0; c < 5; c++) begin
            cyc();
            check("div0_step", 32'(lamps != prev), 32'd1);
            prev = lamps;
        end
        wait_for(0, 0, "w_div_idle");

        // Auto-repeat: done pulse then straight back into UP1.
        auto_rpt = 1'b1;
        start_seq();
        for (int c = 0; c < 200 && !done; c++) cyc();
        check("ar_done", 32'(done), 32'd1);
        check("ar_busy", 32'(busy), 32'd1);
        cyc();
        auto_rpt = 1'b0;
        check("ar_stage", 32'(stage), 32'd1);
        check("ar_lamps", 32'(lamps), 32'h0001);
        check("ar_done_clr", 32'(done), 32'd0);
        wait_for(0, 0, "w_ar_idle");

        // Reset mid-UP3.
        start_seq();
        wait_for(5, 10, "w_rst_up3");
        check("pre_rst_lamps", 32'(lamps), 32'h03FF);
        @(negedge clk) rst = 1'b1;
        cyc();
        check("mid_rst_lamps", 32'(lamps), 32'h0);
        check("mid_rst_stage", 32'(stage), 32'd0);
        check("mid_rst_busy",  32'(busy),  32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
